dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data-cache controller for the MEM stage. It sits between the EX/MEM pipeline register and the MEM/WB register. It returns load data combinationally on a hit. On a miss it drives a line-wide handshake to off-chip data memory. Its stall output feeds the hold inputs of every pipeline register, including MEM/WB.

---
 rtl/dcache_ctrl.sv | 147 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data-cache controller
// for the MEM stage. Loads return data combinationally on a hit; a miss stalls
// the pipeline while an optional victim write-back and a line fetch run over a
// line-wide (256-bit) handshake with off-chip data memory.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   p_addr_i, p_data_i   byte address (word-aligned) and store data
//   p_MemRead_i          load request
//   p_MemWrite_i         store request (wins when both requests are high)
//   p_data_o             load data, valid on a load with p_stall_o=0, else 0
//   p_stall_o            hold request to all pipeline registers
//   mem_addr_o           line address to memory (bits [4:0] always 0)
//   mem_data_o           victim line during write-back
//   mem_enable_o         memory request valid
//   mem_write_o          1 = write-back, 0 = line fetch
//   mem_data_i           fetched line, sampled on the ack edge
//   mem_ack_i            one-cycle completion pulse from memory
module dcache_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  p_addr_i,
  input  logic [31:0]  p_data_i,
  input  logic         p_MemRead_i,
  input  logic         p_MemWrite_i,
  output logic [31:0]  p_data_o,
  output logic         p_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int LINES    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 32 - 5 - INDEX_BITS;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    r_dirty;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [255:0]        r_data [LINES];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [7:0]            w_bit_ofs;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_idle_hit;
  logic                  w_store_hit;
  logic                  w_fill;
  logic [255:0]          w_line;
  logic                  w_unused;

  assign w_idx     = p_addr_i[5 +: INDEX_BITS];
  assign w_tag     = p_addr_i[31 -: TAG_BITS];
  assign w_bit_ofs = {p_addr_i[4:2], 5'b0};
  assign w_unused  = ^p_addr_i[1:0];

  assign w_line      = r_data[w_idx];
  assign w_req       = p_MemRead_i || p_MemWrite_i;
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_idle_hit  = (r_state == S_IDLE) && w_hit;
  assign w_store_hit = p_MemWrite_i && w_idle_hit;
  // Only an ack seen while fetching installs a line; acks elsewhere are ignored.
  assign w_fill      = (r_state == S_ALLOCATE) && mem_ack_i;

  assign p_stall_o = w_req && !w_idle_hit;
  // A store wins over a simultaneous load, so no read data is returned then.
  assign p_data_o  = (p_MemRead_i && !p_MemWrite_i && w_idle_hit) ?
                     w_line[w_bit_ofs +: 32] : 32'h0;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_req && !w_hit)
                     w_next_state = r_dirty[w_idx] ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: if (mem_ack_i) w_next_state = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ack_i) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Memory handshake is decoded from the state alone, so an asynchronous reset
  // of r_state drops the request immediately. Address/data stay steady until
  // ack because the pipeline holds p_addr_i while stalled.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = '0;
    case (r_state)
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[w_idx], w_idx, 5'b0};
        mem_data_o   = w_line;
      end
      S_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {w_tag, w_idx, 5'b0};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_store_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the cleared valid
  // bits make their contents irrelevant, and leaving them out keeps the arrays
  // mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_data_i;
    end else if (w_store_hit) begin
      r_data[w_idx][w_bit_ofs +: 32] <= p_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  p_addr_i;
  logic [31:0]  p_data_i;
  logic         p_MemRead_i;
  logic         p_MemWrite_i;
  logic [31:0]  p_data_o;
  logic         p_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_ctrl #(.INDEX_BITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .p_addr_i     (p_addr_i),
    .p_data_i     (p_data_i),
    .p_MemRead_i  (p_MemRead_i),
    .p_MemWrite_i (p_MemWrite_i),
    .p_data_o     (p_data_o),
    .p_stall_o    (p_stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model + scoreboard of expected requests ----------
  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } req_t;

  req_t         exp_q[$];
  logic [255:0] mem_model [logic [31:0]];
  int           lat        = 10;
  int           n_req      = 0;
  int           n_wr_cyc   = 0;
  bit           inject_ack = 0;

  function automatic logic [255:0] pat_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = 32'hA500_0000 | (a + 32'(4 * w));
    return l;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pat_line(a);
  endfunction

  function automatic logic [31:0] get_word(input logic [31:0] a);
    logic [255:0] l;
    l = get_line({a[31:5], 5'b0});
    return l[{a[4:2], 5'b0} +: 32];
  endfunction

  task automatic push_req(input bit wr, input logic [31:0] addr, input logic [255:0] data);
    req_t e;
    e.wr = wr; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // Memory responder: ack arrives in the lat-th cycle of an enable window.
  initial begin
    int          cnt;
    logic [31:0] cap_addr;
    logic        cap_wr;
    bit          wb_acked;
    bit          injected;
    req_t        e;
    cnt = 0; wb_acked = 0; injected = 0; cap_addr = '0; cap_wr = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (wb_acked) begin
        wb_acked = 0;
        check("wb_to_alloc_enable", mem_enable_o, 1'b1);
        check("wb_to_alloc_write", mem_write_o, 1'b0);
      end
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end
      if (inject_ack && !injected) begin
        injected   = 1;
        mem_ack_i  = 1'b1;
        mem_data_i = {8{32'hBAD0_BAD0}};
      end else if (!reset && mem_enable_o) begin
        if (cnt == 0) begin
          cap_addr = mem_addr_o;
          cap_wr   = mem_write_o;
          n_req++;
          if (exp_q.size() == 0) begin
            check("unexpected_req", mem_enable_o, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("req_write", mem_write_o, e.wr);
            check("req_addr", mem_addr_o, e.addr);
            if (e.wr) check("wb_data", mem_data_o, e.data);
          end
        end else begin
          check("req_steady", {mem_write_o, mem_addr_o}, {cap_wr, cap_addr});
        end
        if (mem_write_o) n_wr_cyc++;
        cnt++;
        if (cnt >= lat) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) begin
            mem_model[mem_addr_o] = mem_data_o;
            mem_data_i = '0;
            wb_acked   = 1;
          end else begin
            mem_data_i = get_line(mem_addr_o);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- one processor access, bounded wait ----------------------
  task automatic access(input string tag, input bit st, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_stall,
                        input logic [31:0] exp_rd);
    int n;
    bit first;
    bit done;
    p_addr_i     = addr;
    p_data_i     = wdata;
    p_MemRead_i  = !st;
    p_MemWrite_i = st;
    n = 0; first = 1; done = 0;
    while (!done) begin
      @(negedge clk);
      if (first && p_stall_o) check({tag, "_enable_cycle0"}, mem_enable_o, 1'b0);
      first = 0;
      if (!p_stall_o) begin
        done = 1;
      end else begin
        n++;
        if (n > 300) begin
          check({tag, "_timeout"}, p_stall_o, 1'b0);
          done = 1;
        end
      end
    end
    check({tag, "_stall_cycles"}, 256'(n), 256'(exp_stall));
    if (!st) check({tag, "_rdata"}, p_data_o, exp_rd);
    @(posedge clk);
    #1;
    p_MemRead_i  = 1'b0;
    p_MemWrite_i = 1'b0;
  endtask

  // ---------------- table of directed vectors -------------------------------
  typedef struct {
    bit           st;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    int           lat;
    int           stall;
    logic [31:0]  rd;
    bit           fetch;
    bit           wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input bit st, input logic [31:0] addr, input logic [31:0] wdata,
                              input int l, input int stall, input logic [31:0] rd,
                              input bit fetch, input bit wb, input logic [31:0] wb_addr,
                              input logic [255:0] wb_line);
    vec_t v;
    v.st = st; v.addr = addr; v.wdata = wdata; v.lat = l; v.stall = stall; v.rd = rd;
    v.fetch = fetch; v.wb = wb; v.wb_addr = wb_addr; v.wb_line = wb_line;
    return v;
  endfunction

  initial begin
    logic [255:0] l40;
    logic [255:0] l80;
    logic [255:0] seed;
    int           wr0;
    int           nr0;
    int           n;

    l40 = pat_line(32'h40);
    l40[31:0]  = 32'h1111_1111;
    seed = l40;
    mem_model[32'h40] = seed;
    l40[63:32] = 32'hDEAD_BEEF;
    l80 = pat_line(32'h80);
    l80[63:32] = 32'h1234_5678;

    //                 st  addr          wdata         lat stall rd            fetch wb wb_addr  wb_line
    vecs[0]  = mk(0, 32'h0000_0040, 32'h0,          10, 11, 32'h1111_1111, 1, 0, 32'h0,  '0);
    vecs[1]  = mk(1, 32'h0000_0044, 32'hDEAD_BEEF,  10,  0, 32'h0,         0, 0, 32'h0,  '0);
    vecs[2]  = mk(0, 32'h0000_0044, 32'h0,          10,  0, 32'hDEAD_BEEF, 0, 0, 32'h0,  '0);
    vecs[3]  = mk(0, 32'h0000_0048, 32'h0,          10,  0, 32'hA500_0048, 0, 0, 32'h0,  '0);
    vecs[4]  = mk(0, 32'h0000_0440, 32'h0,          10, 21, 32'hA500_0440, 1, 1, 32'h40, l40);
    vecs[5]  = mk(0, 32'h0000_0040, 32'h0,          10, 11, 32'h1111_1111, 1, 0, 32'h0,  '0);
    vecs[6]  = mk(0, 32'h0000_0044, 32'h0,          10,  0, 32'hDEAD_BEEF, 0, 0, 32'h0,  '0);
    vecs[7]  = mk(1, 32'h0000_0084, 32'h1234_5678,   3,  4, 32'h0,         1, 0, 32'h0,  '0);
    vecs[8]  = mk(0, 32'h0000_0084, 32'h0,           3,  0, 32'h1234_5678, 0, 0, 32'h0,  '0);
    vecs[9]  = mk(0, 32'h0000_0484, 32'h0,           3,  7, 32'hA500_0484, 1, 1, 32'h80, l80);
    vecs[10] = mk(0, 32'h0000_009C, 32'h0,           3,  4, 32'hA500_009C, 1, 0, 32'h0,  '0);

    reset = 1'b1;
    p_addr_i = '0; p_data_i = '0; p_MemRead_i = 1'b0; p_MemWrite_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_stall", p_stall_o, 1'b0);
    check("rst_rdata", p_data_o, 32'h0);
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_write", mem_write_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_data_o, 256'h0);

    // Stray ack in IDLE must not install a line (vector 0 must still miss)
    inject_ack = 1;
    repeat (3) @(negedge clk);
    check("idle_ack_enable", mem_enable_o, 1'b0);
    check("idle_ack_stall", p_stall_o, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      lat = vecs[i].lat;
      if (vecs[i].wb) push_req(1'b1, vecs[i].wb_addr, vecs[i].wb_line);
      if (vecs[i].fetch) push_req(1'b0, {vecs[i].addr[31:5], 5'b0}, '0);
      wr0 = n_wr_cyc;
      access($sformatf("vec%0d", i), vecs[i].st, vecs[i].addr, vecs[i].wdata,
             vecs[i].stall, vecs[i].rd);
      if (vecs[i].fetch && !vecs[i].wb) check($sformatf("vec%0d_no_wb", i), 256'(n_wr_cyc), 256'(wr0));
    end

    // Reset three cycles into ALLOCATE aborts the fetch
    lat = 20;
    push_req(1'b0, 32'h0000_00C0, '0);
    p_addr_i = 32'h0000_00C0; p_MemRead_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_enable_o && n < 50);
    check("abort_enable_seen", mem_enable_o, 1'b1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_enable_async", mem_enable_o, 1'b0);
    check("abort_addr_async", mem_addr_o, 32'h0);
    @(posedge clk);
    #1 p_MemRead_i = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_idle_enable", mem_enable_o, 1'b0);
    check("abort_idle_stall", p_stall_o, 1'b0);
    @(posedge clk);
    #1;
    lat = 10;
    push_req(1'b0, 32'h0000_00C0, '0);
    access("abort_reload", 1'b0, 32'h0000_00C0, 32'h0, 11, get_word(32'h0000_00C0));

    // Index sweep twice: 32 misses, then 32 hits with no memory traffic
    lat = 2;
    for (int i = 0; i < 32; i++) begin
      push_req(1'b0, 32'h0000_2000 + 32'(i * 32), '0);
      access($sformatf("sweep1_%0d", i), 1'b0, 32'h0000_2000 + 32'(i * 32) + 32'(4 * (i % 8)),
             32'h0, 3, get_word(32'h0000_2000 + 32'(i * 32) + 32'(4 * (i % 8))));
    end
    nr0 = n_req;
    for (int i = 0; i < 32; i++) begin
      access($sformatf("sweep2_%0d", i), 1'b0, 32'h0000_2000 + 32'(i * 32) + 32'(4 * (i % 8)),
             32'h0, 0, get_word(32'h0000_2000 + 32'(i * 32) + 32'(4 * (i % 8))));
    end
    repeat (3) @(negedge clk);
    check("sweep2_no_stray_req", 256'(n_req), 256'(nr0));
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
